// File: rtl/miriscv_prefetch_fetch.sv
// Instruction prefetch/fetch stage: issues pipelined memory requests into a small FIFO
// and presents one instruction per cycle, with static backward-taken branch prediction.
module miriscv_prefetch_fetch #(
   parameter int XLEN            = 32,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter bit BRANCH_PRED_EN  = 1'b1
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic [XLEN-1:0] boot_addr_i,
   output logic            instr_req_o,
   input  logic            instr_gnt_i,
   output logic [XLEN-1:0] instr_addr_o,
   input  logic            instr_rvalid_i,
   input  logic [31:0]     instr_rdata_i,
   input  logic [XLEN-1:0] cu_pc_bra_i,
   input  logic            cu_stall_f_i,
   input  logic            cu_kill_f_i,
   input  logic            cu_boot_addr_load_en_i,
   output logic [XLEN-1:0] fetched_pc_addr_o,
   output logic [XLEN-1:0] fetched_pc_next_addr_o,
   output logic [31:0]     instr_o,
   output logic            fetch_rvalid_o
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0]      NOP     = 32'h0000_0013;
   localparam logic [CNT_W-1:0] MAX_OS  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   logic [XLEN-1:0]  r_pf_pc;
   logic [XLEN-1:0]  r_resp_pc;
   logic [CNT_W-1:0] r_os;
   logic [CNT_W-1:0] r_discard;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [31:0]      r_fifo_instr [FIFO_DEPTH];
   logic [XLEN-1:0]  r_fifo_pc    [FIFO_DEPTH];
   logic [31:0]      r_instr;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_pc_next;
   logic             r_valid;

   logic [31:0]      w_head_instr;
   logic [XLEN-1:0]  w_head_pc;
   logic [12:0]      w_br_imm;
   logic [XLEN-1:0]  w_br_target;
   logic [XLEN-1:0]  w_pred_next;
   logic [XLEN-1:0]  w_flush_target;
   logic             w_pred_taken;
   logic             w_pop;
   logic             w_redirect;
   logic             w_flush;
   logic             w_req;
   logic             w_gnt;
   logic             w_rvalid;
   logic             w_push;

   assign w_head_instr = r_fifo_instr[r_rd_ptr];
   assign w_head_pc    = r_fifo_pc[r_rd_ptr];
   assign w_br_imm     = {w_head_instr[31], w_head_instr[7], w_head_instr[30:25],
                          w_head_instr[11:8], 1'b0};
   assign w_br_target  = w_head_pc + {{(XLEN-13){w_br_imm[12]}}, w_br_imm};
   assign w_pred_taken = BRANCH_PRED_EN && (w_head_instr[6:0] == 7'b1100011) && w_head_instr[31];
   assign w_pred_next  = w_pred_taken ? w_br_target : (w_head_pc + XLEN'(4));

   assign w_pop      = !cu_stall_f_i && (r_count != '0) && !cu_boot_addr_load_en_i && !cu_kill_f_i;
   assign w_redirect = w_pop && w_pred_taken;
   assign w_flush    = cu_boot_addr_load_en_i || cu_kill_f_i || w_redirect;

   // Requests are throttled so every in-flight response is guaranteed a FIFO slot.
   assign w_req    = arstn_i && !w_flush && (r_os < MAX_OS) &&
                     (({1'b0, r_os} + {1'b0, r_count}) < DEPTH_C);
   assign w_gnt    = w_req && instr_gnt_i;
   // A response with nothing outstanding is a leftover from before reset.
   assign w_rvalid = instr_rvalid_i && (r_os != '0);
   assign w_push   = w_rvalid && (r_discard == '0) && !w_flush;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_flush_target = w_br_target;
      if (cu_boot_addr_load_en_i) w_flush_target = boot_addr_i;
      else if (cu_kill_f_i)       w_flush_target = cu_pc_bra_i;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_pf_pc   <= '0;
         r_resp_pc <= '0;
         r_os      <= '0;
         r_discard <= '0;
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
      end else begin
         r_os <= r_os + CNT_W'(w_gnt) - CNT_W'(w_rvalid);
         if (w_flush) begin
            r_pf_pc   <= w_flush_target;
            r_resp_pc <= w_flush_target;
            r_discard <= r_os - CNT_W'(w_rvalid);
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
         end else begin
            if (w_gnt) r_pf_pc <= r_pf_pc + XLEN'(4);
            if (w_rvalid && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
            if (w_push) begin
               r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
               r_resp_pc <= r_resp_pc + XLEN'(4);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

   // NOTE: FIFO storage is deliberately not reset; r_count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= instr_rdata_i;
         r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_instr   <= NOP;
         r_pc      <= '0;
         r_pc_next <= '0;
         r_valid   <= 1'b0;
      end else if (cu_boot_addr_load_en_i || cu_kill_f_i) begin
         r_instr <= NOP;
         r_valid <= 1'b0;
      end else if (!cu_stall_f_i) begin
         if (w_pop) begin
            r_instr   <= w_head_instr;
            r_pc      <= w_head_pc;
            r_pc_next <= w_pred_next;
            r_valid   <= 1'b1;
         end else begin
            r_instr <= NOP;
            r_valid <= 1'b0;
         end
      end
   end

   assign instr_req_o            = w_req;
   assign instr_addr_o           = r_pf_pc;
   assign instr_o                = r_instr;
   assign fetched_pc_addr_o      = r_pc;
   assign fetched_pc_next_addr_o = r_pc_next;
   assign fetch_rvalid_o         = r_valid;

endmodule

// File: tb/tb_miriscv_prefetch_fetch.sv
// Directed bench for miriscv_prefetch_fetch: two instances (prediction on/off) share the
// control inputs, each served by its own lane of a 1- or 2-cycle-latency memory model.
module tb_miriscv_prefetch_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i;
   logic        arstn_i;
   logic [31:0] boot_addr_i;
   logic        instr_gnt_i;
   logic [31:0] cu_pc_bra_i;
   logic        cu_stall_f_i;
   logic        cu_kill_f_i;
   logic        cu_boot_addr_load_en_i;

   logic        req0, req1, rvalid0, rvalid1, fvalid0, fvalid1;
   logic [31:0] addr0, addr1, rdata0, rdata1;
   logic [31:0] fpc0, fpc1, fnext0, fnext1, finstr0, finstr1;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          lat      = 1;
   bit          stale    = 1'b0;

   miriscv_prefetch_fetch u_dut (
      .clk_i(clk_i), .arstn_i(arstn_i), .boot_addr_i(boot_addr_i),
      .instr_req_o(req0), .instr_gnt_i(instr_gnt_i), .instr_addr_o(addr0),
      .instr_rvalid_i(rvalid0), .instr_rdata_i(rdata0),
      .cu_pc_bra_i(cu_pc_bra_i), .cu_stall_f_i(cu_stall_f_i), .cu_kill_f_i(cu_kill_f_i),
      .cu_boot_addr_load_en_i(cu_boot_addr_load_en_i),
      .fetched_pc_addr_o(fpc0), .fetched_pc_next_addr_o(fnext0),
      .instr_o(finstr0), .fetch_rvalid_o(fvalid0)
   );

   miriscv_prefetch_fetch #(.BRANCH_PRED_EN(1'b0)) u_dut_np (
      .clk_i(clk_i), .arstn_i(arstn_i), .boot_addr_i(boot_addr_i),
      .instr_req_o(req1), .instr_gnt_i(instr_gnt_i), .instr_addr_o(addr1),
      .instr_rvalid_i(rvalid1), .instr_rdata_i(rdata1),
      .cu_pc_bra_i(cu_pc_bra_i), .cu_stall_f_i(cu_stall_f_i), .cu_kill_f_i(cu_kill_f_i),
      .cu_boot_addr_load_en_i(cu_boot_addr_load_en_i),
      .fetched_pc_addr_o(fpc1), .fetched_pc_next_addr_o(fnext1),
      .instr_o(finstr1), .fetch_rvalid_o(fvalid1)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'hFE00_0EE3;
      return {a[21:2], 12'h013};
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic wait_fetch(input int d, input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_next, input logic [31:0] e_instr,
                             input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk_i);
         if ((d == 0) ? fvalid0 : fvalid1) found = 1'b1;
      end
      check({tag, "_seen"}, found, 1);
      if (found) begin
         check({tag, "_pc"},    (d == 0) ? fpc0 : fpc1, e_pc);
         check({tag, "_next"},  (d == 0) ? fnext0 : fnext1, e_next);
         check({tag, "_instr"}, (d == 0) ? finstr0 : finstr1, e_instr);
      end
   endtask

   // Memory model: grants sampled 2 time units after each falling edge, answered
   // lat cycles later; stale forces a spurious response.
   initial begin
      bit          s0v [2];
      bit          s1v [2];
      logic [31:0] s0a [2];
      logic [31:0] s1a [2];
      bit          v;
      logic [31:0] a;
      for (int d = 0; d < 2; d++) begin
         s0v[d] = 1'b0; s1v[d] = 1'b0; s0a[d] = '0; s1a[d] = '0;
      end
      rvalid0 = 1'b0; rvalid1 = 1'b0; rdata0 = '0; rdata1 = '0;
      forever begin
         @(negedge clk_i);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (stale)         begin v = 1'b1;   a = 32'hDEAD_0000; end
            else if (lat == 2) begin v = s1v[d]; a = s1a[d]; end
            else               begin v = s0v[d]; a = s0a[d]; end
            if (d == 0) begin rvalid0 = v; rdata0 = mem_word(a); end
            else        begin rvalid1 = v; rdata1 = mem_word(a); end
            s1v[d] = s0v[d]; s1a[d] = s0a[d]; s0v[d] = 1'b0;
         end
         #1;
         s0v[0] = req0 && instr_gnt_i && arstn_i; s0a[0] = addr0;
         s0v[1] = req1 && instr_gnt_i && arstn_i; s0a[1] = addr1;
      end
   end

   initial begin
      arstn_i = 1'b1; boot_addr_i = '0; instr_gnt_i = 1'b0; cu_pc_bra_i = '0;
      cu_stall_f_i = 1'b0; cu_kill_f_i = 1'b0; cu_boot_addr_load_en_i = 1'b0;
      #2 arstn_i = 1'b0;
      #1;
      check("rst_valid", fvalid0, 0);
      check("rst_instr", finstr0, NOP);
      check("rst_pc",    fpc0, 0);
      check("rst_next",  fnext0, 0);
      check("rst_req",   req0, 0);
      check("rst_addr",  addr0, 0);

      // Boot stream: back-to-back sequential fetches.
      repeat (2) @(negedge clk_i);
      arstn_i = 1'b1;
      @(negedge clk_i);
      boot_addr_i = 32'h8000_0000; cu_boot_addr_load_en_i = 1'b1; instr_gnt_i = 1'b1;
      @(negedge clk_i);
      cu_boot_addr_load_en_i = 1'b0;
      wait_fetch(0, "boot0", 32'h8000_0000, 32'h8000_0004, mem_word(32'h8000_0000), 8);
      for (int k = 1; k < 4; k++)
         wait_fetch(0, "boot_b2b", 32'h8000_0000 + 4*k, 32'h8000_0004 + 4*k,
                    mem_word(32'h8000_0000 + 4*k), 1);

      // Stall: outputs hold, requests stop once the FIFO is committed, nothing lost.
      cu_stall_f_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         check("stall_hold_pc", fpc0, 32'h8000_000C);
      end
      check("stall_hold_valid", fvalid0, 1);
      check("stall_req_low",    req0, 0);
      cu_stall_f_i = 1'b0;
      for (int k = 0; k < 6; k++)
         wait_fetch(0, "post_stall", 32'h8000_0010 + 4*k, 32'h8000_0014 + 4*k,
                    mem_word(32'h8000_0010 + 4*k), 3);

      // Kill with two responses in flight (2-cycle memory latency).
      instr_gnt_i = 1'b0;
      repeat (4) @(negedge clk_i);
      lat = 2;
      @(negedge clk_i);
      boot_addr_i = 32'h0000_0300; cu_boot_addr_load_en_i = 1'b1;
      @(negedge clk_i);
      cu_boot_addr_load_en_i = 1'b0; instr_gnt_i = 1'b1;
      repeat (2) @(negedge clk_i);
      cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h0000_0100;
      @(negedge clk_i);
      cu_kill_f_i = 1'b0;
      check("kill_valid", fvalid0, 0);
      check("kill_instr", finstr0, NOP);
      wait_fetch(0, "kill0", 32'h0000_0100, 32'h0000_0104, mem_word(32'h0000_0100), 10);
      wait_fetch(0, "kill1", 32'h0000_0104, 32'h0000_0108, mem_word(32'h0000_0104), 4);

      // Backward branch at 0x200: predicted by u_dut, fall-through on u_dut_np.
      instr_gnt_i = 1'b0;
      repeat (4) @(negedge clk_i);
      lat = 1;
      @(negedge clk_i);
      boot_addr_i = 32'h0000_0200; cu_boot_addr_load_en_i = 1'b1;
      @(negedge clk_i);
      cu_boot_addr_load_en_i = 1'b0; instr_gnt_i = 1'b1;
      fork
         begin
            wait_fetch(0, "bp_br", 32'h0000_0200, 32'h0000_01FC, 32'hFE00_0EE3, 8);
            check("bp_pf_pc", addr0, 32'h0000_01FC);
            wait_fetch(0, "bp_tgt", 32'h0000_01FC, 32'h0000_0200, mem_word(32'h0000_01FC), 8);
         end
         begin
            wait_fetch(1, "np_br", 32'h0000_0200, 32'h0000_0204, 32'hFE00_0EE3, 8);
            wait_fetch(1, "np_seq", 32'h0000_0204, 32'h0000_0208, mem_word(32'h0000_0204), 1);
         end
      join

      // Reset mid-burst, then a stale response after release.
      arstn_i = 1'b0;
      #1;
      check("mid_rst_valid", fvalid0, 0);
      check("mid_rst_instr", finstr0, NOP);
      check("mid_rst_pc",    fpc0, 0);
      check("mid_rst_next",  fnext0, 0);
      check("mid_rst_req",   req0, 0);
      check("mid_rst_np_valid", fvalid1, 0);
      @(negedge clk_i);
      instr_gnt_i = 1'b0;
      @(negedge clk_i);
      arstn_i = 1'b1;
      @(negedge clk_i);
      stale = 1'b1;
      @(negedge clk_i);
      stale = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("stale_ignored", fvalid0, 0);
      end
      check("post_rst_req",  req0, 1);
      check("post_rst_addr", addr0, 0);
      instr_gnt_i = 1'b1;
      wait_fetch(0, "post_rst", 32'h0000_0000, 32'h0000_0004, mem_word(32'h0000_0000), 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
